reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Multi-ported, parametrised register file for the RV32I core that replaces the single-write-port file. It provides a configurable number of read ports and write ports, and optional write-to-read bypass. A per-register pending scoreboard lets the pipelined datapath detect read-after-write hazards. The debug view port and the a0 tap used by the top-level display logic are kept.

## Interface
Parameters:
- ADDRESS_WIDTH, 5, register address width; the file holds 2**ADDRESS_WIDTH registers.
- DATA_WIDTH, 32, register width.
- READ_PORTS, 2, number of read ports (1–4).
- WRITE_PORTS, 2, number of write ports (1–2).
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return the stored value.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- A_R  in  READ_PORTS*ADDRESS_WIDTH  read addresses; port i is at slice [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- RD  out  READ_PORTS*DATA_WIDTH  read data; port i is at slice [i*DATA_WIDTH +: DATA_WIDTH].
- BUSY  out  READ_PORTS  per-read-port hazard flag.
- A_W  in  WRITE_PORTS*ADDRESS_WIDTH  write addresses.
- WE  in  WRITE_PORTS  write enables.
- WD  in  WRITE_PORTS*DATA_WIDTH  write data.
- ISSUE_EN  in  1  marks destination ISSUE_A as pending.
- ISSUE_A  in  ADDRESS_WIDTH  destination register of the issued instruction.
- PENDING_CNT  out  ADDRESS_WIDTH+1  registered count of pending registers.
- address_to_view  in  ADDRESS_WIDTH  debug read address.
- reg_output  out  DATA_WIDTH  stored value at address_to_view, never bypassed.
- a0  out  DATA_WIDTH  stored value of register 10, never bypassed.

## Operation
- Register x0 reads as 0 at all times. Writes to x0 are dropped. x0 never becomes pending and never asserts BUSY.
- Write: on the rising edge, for each port w with WE[w]=1 and a nonzero address, registers[A_W[w]] <= WD[w].
- Write conflict: if two ports write the same address in the same cycle, the higher-index port wins.
- Read (combinational):
  - BYPASS=1: if any enabled write port targets the same nonzero address this cycle, RD[i] is that port's WD (highest-index port on a tie).
  - Otherwise, and whenever BYPASS=0, RD[i] is the stored value.
- Scoreboard: one pending bit per register.
  - ISSUE_EN=1 with ISSUE_A≠0 sets pending[ISSUE_A] at the edge.
  - An enabled write to address r clears pending[r] at the edge.
  - If an issue and a write target the same address in the same cycle, the set wins: a new producer supersedes the one being retired.
- BUSY[i] = pending[A_R[i]], except:
  - It is forced to 0 when A_R[i]=0.
  - With BYPASS=1, it is also forced to 0 when an enabled write targets A_R[i] in the current cycle.
- PENDING_CNT equals the number of set pending bits after the edge, i.e. the popcount of the next pending vector, registered. Range is 0 to 2**ADDRESS_WIDTH−1; it cannot overflow.
- Reset (RST_N=0, asynchronous):
  - All registers go to 0, all pending bits to 0, PENDING_CNT to 0.
  - Consequently RD, BUSY, reg_output and a0 all read 0 during reset.
  - Writes and issues presented while RST_N=0 are ignored.
  - Deassertion is clean; the first edge with RST_N=1 is a normal update cycle.

## Timing
- Write latency: data is visible in the stored value one edge after WE.
- With BYPASS=1, read-after-write latency is 0 cycles.
- BUSY and RD are combinational from A_R, WE, A_W and WD. There is no combinational path from ISSUE_EN or ISSUE_A to any output.
- Pending set and clear take effect on the next edge. PENDING_CNT is updated on that same edge.
- reg_output and a0 are combinational from stored state only.

## Test plan
- Reset: write x5=0xDEADBEEF, then assert RST_N=0 mid-cycle -> RD, reg_output and a0 are 0 immediately; PENDING_CNT=0.
- Dual write, distinct addresses: write x3=0x11 on port 0 and x4=0x22 on port 1 -> the next cycle reads return 0x11 and 0x22. A write to x0 -> x0 still reads 0.
- Same-address conflict: port 0 writes x7=0xAAAA and port 1 writes x7=0x5555 -> x7 reads 0x5555. With BYPASS=1 the same-cycle read also returns 0x5555.
- Bypass off: with BYPASS=0, write x9=0x1234 while reading x9 (old value 0) -> RD=0 this cycle and 0x1234 the next cycle.
- Scoreboard:
  - Issue x6 -> BUSY=1 for reads of x6 and PENDING_CNT=1.
  - A write to x6 -> BUSY=0 that cycle (BYPASS=1) and PENDING_CNT=0 after the edge.
  - Issue x6 and write x6 in the same cycle -> x6 remains pending.
- Debug taps: write x10=0xCAFE -> a0=0xCAFE. Set address_to_view=10 while a same-cycle write to x10 is in flight -> reg_output shows the old value.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-ported register file with optional write-to-read bypass and a per-register
// pending scoreboard for read-after-write hazard detection.
module reg_file_mp #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned READ_PORTS    = 2,
  parameter int unsigned WRITE_PORTS   = 2,
  parameter bit          BYPASS        = 1'b1
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic [READ_PORTS*ADDRESS_WIDTH-1:0]  A_R,
  output logic [READ_PORTS*DATA_WIDTH-1:0]     RD,
  output logic [READ_PORTS-1:0]                BUSY,
  input  logic [WRITE_PORTS*ADDRESS_WIDTH-1:0] A_W,
  input  logic [WRITE_PORTS-1:0]               WE,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0]    WD,
  input  logic                                 ISSUE_EN,
  input  logic [ADDRESS_WIDTH-1:0]             ISSUE_A,
  output logic [ADDRESS_WIDTH:0]               PENDING_CNT,
  input  logic [ADDRESS_WIDTH-1:0]             address_to_view,
  output logic [DATA_WIDTH-1:0]                reg_output,
  output logic [DATA_WIDTH-1:0]                a0
);

  localparam int unsigned NumRegs = 2 ** ADDRESS_WIDTH;
  localparam int unsigned A0Idx   = 10;

  logic [DATA_WIDTH-1:0]    regs_q [NumRegs];
  logic [NumRegs-1:0]       pending_q, pending_d;
  logic [ADDRESS_WIDTH:0]   cnt_q, cnt_d;

  logic [ADDRESS_WIDTH-1:0] wa [WRITE_PORTS];
  logic [DATA_WIDTH-1:0]    wd [WRITE_PORTS];
  logic [WRITE_PORTS-1:0]   wr_valid;

  // Writes held off during reset so the bypass path cannot leak data while RST_N=0.
  always_comb begin
    wr_valid = '0;
    for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
      wa[w]       = A_W[w*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      wd[w]       = WD[w*DATA_WIDTH +: DATA_WIDTH];
      wr_valid[w] = WE[w] & RST_N & (wa[w] != '0);
    end
  end

  // Clear on write first, then set on issue, so a new producer wins the tie.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
      if (wr_valid[w]) pending_d[wa[w]] = 1'b0;
    end
    if (ISSUE_EN) pending_d[ISSUE_A] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned r = 0; r < NumRegs; r++) begin
      cnt_d = cnt_d + (ADDRESS_WIDTH + 1)'(pending_d[r]);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned r = 0; r < NumRegs; r++) regs_q[r] <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      // Later ports are assigned last, so the higher index wins a conflict.
      for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
        if (wr_valid[w]) regs_q[wa[w]] <= wd[w];
      end
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  logic [ADDRESS_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0]    rdata;
  logic                     rbusy;

  always_comb begin
    RD    = '0;
    BUSY  = '0;
    ra    = '0;
    rdata = '0;
    rbusy = 1'b0;
    for (int unsigned i = 0; i < READ_PORTS; i++) begin
      ra    = A_R[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      rdata = regs_q[ra];
      rbusy = pending_q[ra];
      if (BYPASS) begin
        for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
          if (wr_valid[w] && (wa[w] == ra)) begin
            rdata = wd[w];
            rbusy = 1'b0;
          end
        end
      end
      if (ra == '0) begin
        rdata = '0;
        rbusy = 1'b0;
      end
      RD[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
      BUSY[i]                        = rbusy;
    end
  end

  assign PENDING_CNT = cnt_q;
  assign reg_output  = regs_q[address_to_view];
  assign a0          = regs_q[A0Idx];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one instance with bypass, one without, sharing stimulus.
module tb_reg_file_mp;

  logic        CLK;
  logic        rst_n;
  logic [9:0]  a_r;
  logic [9:0]  a_w;
  logic [1:0]  we;
  logic [63:0] wd;
  logic        issue_en;
  logic [4:0]  issue_a;
  logic [4:0]  view;

  logic [63:0] rd, rd_nb;
  logic [1:0]  busy, busy_nb;
  logic [5:0]  cnt, cnt_nb;
  logic [31:0] reg_out, reg_out_nb, a0, a0_nb;
  logic [31:0] rd0, rd1, rdn0, rdn1;

  int errors = 0;
  int checks = 0;

  assign rd0  = rd[31:0];
  assign rd1  = rd[63:32];
  assign rdn0 = rd_nb[31:0];
  assign rdn1 = rd_nb[63:32];

  reg_file_mp #(.BYPASS(1'b1)) dut (
    .CLK(CLK), .RST_N(rst_n), .A_R(a_r), .RD(rd), .BUSY(busy), .A_W(a_w), .WE(we), .WD(wd),
    .ISSUE_EN(issue_en), .ISSUE_A(issue_a), .PENDING_CNT(cnt), .address_to_view(view),
    .reg_output(reg_out), .a0(a0)
  );

  reg_file_mp #(.BYPASS(1'b0)) dut_nb (
    .CLK(CLK), .RST_N(rst_n), .A_R(a_r), .RD(rd_nb), .BUSY(busy_nb), .A_W(a_w), .WE(we),
    .WD(wd), .ISSUE_EN(issue_en), .ISSUE_A(issue_a), .PENDING_CNT(cnt_nb),
    .address_to_view(view), .reg_output(reg_out_nb), .a0(a0_nb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    we       = 2'b00;
    a_w      = '0;
    wd       = '0;
    issue_en = 1'b0;
    issue_a  = '0;
  endtask

  task automatic set_w(input int p, input logic [4:0] addr, input logic [31:0] data);
    we[p]             = 1'b1;
    a_w[p*5 +: 5]     = addr;
    wd[p*32 +: 32]    = data;
  endtask

  task automatic test_reset();
    idle();
    a_r = {5'd10, 5'd5};
    view = 5'd5;
    set_w(0, 5'd5, 32'hDEADBEEF);
    set_w(1, 5'd10, 32'h0000A0A0);
    issue_en = 1'b1;
    issue_a  = 5'd8;
    step();
    idle();
    #1;
    checks++;
    if (rd0 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL pre_reset_x5 got=%h exp=%h", rd0, 32'hDEADBEEF);
    end
    checks++;
    if (cnt !== 6'd1) begin
      errors++; $display("FAIL pre_reset_cnt got=%0d exp=1", cnt);
    end
    // Mid-cycle asynchronous reset with a write and issue still presented.
    #2 rst_n = 1'b0;
    set_w(0, 5'd5, 32'h12345678);
    issue_en = 1'b1;
    issue_a  = 5'd3;
    #1;
    checks++;
    if (rd0 !== 32'h0) begin
      errors++; $display("FAIL reset_rd0 got=%h exp=0", rd0);
    end
    checks++;
    if (reg_out !== 32'h0 || a0 !== 32'h0) begin
      errors++; $display("FAIL reset_taps got=%h/%h exp=0/0", reg_out, a0);
    end
    checks++;
    if (cnt !== 6'd0 || busy !== 2'b00) begin
      errors++; $display("FAIL reset_cnt_busy got=%0d/%b exp=0/00", cnt, busy);
    end
    step();
    checks++;
    if (reg_out !== 32'h0 || cnt !== 6'd0) begin
      errors++; $display("FAIL reset_ignore got=%h/%0d exp=0/0", reg_out, cnt);
    end
    rst_n = 1'b1;
    idle();
    step();
  endtask

  task automatic test_dual_write();
    idle();
    set_w(0, 5'd3, 32'h11);
    set_w(1, 5'd4, 32'h22);
    step();
    idle();
    a_r = {5'd4, 5'd3};
    #1;
    checks++;
    if (rd0 !== 32'h11 || rd1 !== 32'h22) begin
      errors++; $display("FAIL dual_write got=%h/%h exp=11/22", rd0, rd1);
    end
    checks++;
    if (rdn0 !== 32'h11 || rdn1 !== 32'h22) begin
      errors++; $display("FAIL dual_write_nb got=%h/%h exp=11/22", rdn0, rdn1);
    end
    set_w(0, 5'd0, 32'hFFFF);
    a_r = {5'd3, 5'd0};
    #1;
    checks++;
    if (rd0 !== 32'h0) begin
      errors++; $display("FAIL x0_bypass got=%h exp=0", rd0);
    end
    step();
    idle();
    view = 5'd0;
    #1;
    checks++;
    if (rd0 !== 32'h0 || reg_out !== 32'h0 || busy[0] !== 1'b0) begin
      errors++; $display("FAIL x0_write got=%h/%h/%b exp=0/0/0", rd0, reg_out, busy[0]);
    end
  endtask

  task automatic test_conflict();
    idle();
    set_w(0, 5'd7, 32'hAAAA);
    set_w(1, 5'd7, 32'h5555);
    a_r = {5'd3, 5'd7};
    #1;
    checks++;
    if (rd0 !== 32'h5555) begin
      errors++; $display("FAIL conflict_bypass got=%h exp=5555", rd0);
    end
    checks++;
    if (rdn0 !== 32'h0) begin
      errors++; $display("FAIL conflict_nb_same_cycle got=%h exp=0", rdn0);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd0 !== 32'h5555 || rdn0 !== 32'h5555) begin
      errors++; $display("FAIL conflict_stored got=%h/%h exp=5555/5555", rd0, rdn0);
    end
  endtask

  task automatic test_no_bypass();
    idle();
    set_w(0, 5'd9, 32'h1234);
    a_r = {5'd9, 5'd3};
    #1;
    checks++;
    if (rdn1 !== 32'h0) begin
      errors++; $display("FAIL nobypass_same_cycle got=%h exp=0", rdn1);
    end
    checks++;
    if (rd1 !== 32'h1234) begin
      errors++; $display("FAIL bypass_same_cycle got=%h exp=1234", rd1);
    end
    step();
    idle();
    #1;
    checks++;
    if (rdn1 !== 32'h1234) begin
      errors++; $display("FAIL nobypass_next got=%h exp=1234", rdn1);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    a_r = {5'd12, 5'd6};
    issue_en = 1'b1;
    issue_a  = 5'd6;
    #1;
    checks++;
    if (busy !== 2'b00) begin
      errors++; $display("FAIL issue_no_comb got=%b exp=00", busy);
    end
    step();
    idle();
    #1;
    checks++;
    if (busy !== 2'b01 || cnt !== 6'd1 || busy_nb !== 2'b01) begin
      errors++; $display("FAIL issue_x6 got=%b/%0d/%b exp=01/1/01", busy, cnt, busy_nb);
    end
    set_w(0, 5'd6, 32'h66);
    #1;
    checks++;
    if (busy[0] !== 1'b0 || busy_nb[0] !== 1'b1) begin
      errors++; $display("FAIL write_clears_busy got=%b/%b exp=0/1", busy[0], busy_nb[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (cnt !== 6'd0 || busy[0] !== 1'b0 || rd0 !== 32'h66) begin
      errors++; $display("FAIL retire_x6 got=%0d/%b/%h exp=0/0/66", cnt, busy[0], rd0);
    end
    set_w(1, 5'd6, 32'h67);
    issue_en = 1'b1;
    issue_a  = 5'd6;
    step();
    idle();
    #1;
    checks++;
    if (busy[0] !== 1'b1 || cnt !== 6'd1) begin
      errors++; $display("FAIL issue_beats_write got=%b/%0d exp=1/1", busy[0], cnt);
    end
    issue_en = 1'b1;
    issue_a  = 5'd0;
    step();
    issue_a  = 5'd12;
    step();
    idle();
    #1;
    checks++;
    if (cnt !== 6'd2 || busy !== 2'b11 || cnt_nb !== 6'd2) begin
      errors++; $display("FAIL two_pending got=%0d/%b/%0d exp=2/11/2", cnt, busy, cnt_nb);
    end
    set_w(0, 5'd6, 32'h6);
    set_w(1, 5'd12, 32'hC);
    step();
    idle();
    #1;
    checks++;
    if (cnt !== 6'd0 || busy !== 2'b00) begin
      errors++; $display("FAIL dual_retire got=%0d/%b exp=0/00", cnt, busy);
    end
  endtask

  task automatic test_debug();
    idle();
    set_w(0, 5'd10, 32'hCAFE);
    step();
    idle();
    #1;
    checks++;
    if (a0 !== 32'hCAFE) begin
      errors++; $display("FAIL a0_tap got=%h exp=cafe", a0);
    end
    view = 5'd10;
    a_r  = {5'd3, 5'd10};
    set_w(1, 5'd10, 32'hBEEF);
    #1;
    checks++;
    if (reg_out !== 32'hCAFE || a0 !== 32'hCAFE || rd0 !== 32'hBEEF) begin
      errors++; $display("FAIL view_no_bypass got=%h/%h/%h exp=cafe/cafe/beef", reg_out, a0, rd0);
    end
    step();
    idle();
    #1;
    checks++;
    if (reg_out !== 32'hBEEF || a0 !== 32'hBEEF) begin
      errors++; $display("FAIL view_after got=%h/%h exp=beef/beef", reg_out, a0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_r   = '0;
    view  = '0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    step();
    test_reset();
    test_dual_write();
    test_conflict();
    test_no_bypass();
    test_scoreboard();
    test_debug();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
